aes_round_sequencer: RTL

- Sequences the AES-128 encryption datapath through round 0 and rounds 1..NUM_ROUNDS.
- Drives level enables to the key-expansion, SubBytes, ShiftRows, MixColumns and AddRoundKey units, and advances on each unit's finished flag.
- Sits between the AHB slave controller (start/done handshake) and the round datapath.
- Also tracks the round index, skips MixColumns in the final round, and enforces a per-stage watchdog.

---
 rtl/aes_round_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// Control sequencer for the AES-128 encryption datapath. Steps round 0 and rounds
// 1..NUM_ROUNDS through the unit enables, tracks the round index and guards each stage.
module aes_round_sequencer #(
  parameter int unsigned NUM_ROUNDS     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic       i_start,
  input  logic       i_key_valid,
  input  logic       i_clear_error,
  input  logic       i_keyexp_finished,
  input  logic       i_sbytes_finished,
  input  logic       i_srows_finished,
  input  logic       i_mcol_finished,
  input  logic       i_around_finished,
  output logic       o_keyex_enable,
  output logic       o_sbytes_enable,
  output logic       o_srows_enable,
  output logic       o_mcol_enable,
  output logic       o_around_enable,
  output logic [3:0] o_round_num,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StArk0,
    StKeyExp,
    StSBytes,
    StSRows,
    StMCol,
    StArk,
    StDone
  } state_e;

  state_e         r_state, w_state_next;
  logic [3:0]     r_round, w_round_next;
  logic [WdW-1:0] r_wd_cnt, w_wd_next;
  logic           r_error, w_error_next;

  logic w_stage_fin;
  logic w_in_stage;
  logic w_timeout;

  // Only the finished flag of the stage currently enabled is observed.
  always_comb begin
    w_stage_fin = 1'b0;
    w_in_stage  = 1'b1;
    case (r_state)
      StArk0:   w_stage_fin = i_around_finished;
      StKeyExp: w_stage_fin = i_keyexp_finished;
      StSBytes: w_stage_fin = i_sbytes_finished;
      StSRows:  w_stage_fin = i_srows_finished;
      StMCol:   w_stage_fin = i_mcol_finished;
      StArk:    w_stage_fin = i_around_finished;
      default:  w_in_stage  = 1'b0;
    endcase
  end

  // A flag arriving in the last allowed cycle wins over the timeout.
  assign w_timeout = w_in_stage && !w_stage_fin && (r_wd_cnt == WdLimit);

  always_comb begin
    w_state_next = r_state;
    w_round_next = r_round;
    w_error_next = r_error;

    if (i_clear_error) begin
      w_error_next = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (i_start && i_key_valid && !r_error && !i_clear_error) begin
          w_state_next = StArk0;
          w_round_next = 4'd0;
        end
      end
      StArk0: begin
        if (w_stage_fin) begin
          w_state_next = StKeyExp;
          w_round_next = 4'd1;
        end
      end
      StKeyExp: begin
        if (w_stage_fin) begin
          w_state_next = StSBytes;
        end
      end
      StSBytes: begin
        if (w_stage_fin) begin
          w_state_next = StSRows;
        end
      end
      StSRows: begin
        // The final round has no MixColumns.
        if (w_stage_fin) begin
          w_state_next = (r_round < LastRound) ? StMCol : StArk;
        end
      end
      StMCol: begin
        if (w_stage_fin) begin
          w_state_next = StArk;
        end
      end
      StArk: begin
        if (w_stage_fin) begin
          if (r_round < LastRound) begin
            w_state_next = StKeyExp;
            w_round_next = r_round + 4'd1;
          end else begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
    endcase

    if (w_timeout) begin
      w_state_next = StIdle;
      w_error_next = 1'b1;
    end
  end

  always_comb begin
    if (w_state_next != r_state) begin
      w_wd_next = '0;
    end else if (w_in_stage) begin
      w_wd_next = r_wd_cnt + 1'b1;
    end else begin
      w_wd_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state  <= StIdle;
      r_round  <= 4'd0;
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_round  <= w_round_next;
      r_wd_cnt <= w_wd_next;
      r_error  <= w_error_next;
    end
  end

  always_comb begin
    o_keyex_enable  = (r_state == StKeyExp);
    o_sbytes_enable = (r_state == StSBytes);
    o_srows_enable  = (r_state == StSRows);
    o_mcol_enable   = (r_state == StMCol);
    o_around_enable = (r_state == StArk0) || (r_state == StArk);
    o_busy          = (r_state != StIdle);
    o_done          = (r_state == StDone);
    o_round_num     = r_round;
    o_error         = r_error;
  end

endmodule
